// File: rtl/ctrl_relojes_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_relojes_pkg
// Shared definitions for the clk32f-derived clock controller:
//   - state_t   : controller state encoding (HOLD / RUN)
//   - M_*       : bit positions inside the 3-bit gating mask
//   - DIV*      : divide ratios of the three derived clocks
//   - B*        : counter width that spans one period of each derived clock
// ---------------------------------------------------------------------------
package ctrl_relojes_pkg;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Gating mask bit positions
  localparam int M_4F = 2;
  localparam int M_2F = 1;
  localparam int M_1F = 0;

  // Divide ratios relative to clk32f
  localparam int DIV4F = 8;
  localparam int DIV2F = 16;
  localparam int DIV1F = 32;

  // Number of low counter bits covering one period of each derived clock.
  // The MSB of each field is the derived clock itself.
  localparam int B4F = $clog2(DIV4F);
  localparam int B2F = $clog2(DIV2F);
  localparam int B1F = $clog2(DIV1F);

endpackage

// File: rtl/contador_div.sv
// ---------------------------------------------------------------------------
// contador_div
// Free-running CNT_W-bit wrap counter with terminal-count decode for the
// three derived clock periods.
//   clk32f : clock
//   rst    : asynchronous active-high reset (counter to 0)
//   en     : count enable; counter holds its value while low
//   cnt    : current count
//   tc4    : low B4F bits all ones (last cycle of a clk4f period)
//   tc2    : low B2F bits all ones (last cycle of a clk2f period)
//   tc1    : whole counter all ones (last cycle of a clk period)
// ---------------------------------------------------------------------------
module contador_div
  import ctrl_relojes_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk32f,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc4,
  output logic             tc2,
  output logic             tc1
);

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk32f or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc4 = &cnt[B4F-1:0];
  assign tc2 = &cnt[B2F-1:0];
  assign tc1 = &cnt;

endmodule

// File: rtl/control_relojes.sv
// ---------------------------------------------------------------------------
// control_relojes
// Sequencing and gating controller for the clk32f-derived clock tree.
// After reset it holds all outputs low for HOLD_CYCLES cycles, then runs the
// divide counter and produces the gated clk4f/clk2f/clk waveforms and their
// end-of-period strobes. Mask changes arrive through a req/ack handshake and
// only take effect on the counter wrap, where every derived clock is low.
//
// Ports
//   clk32f    : sole clock, all logic on posedge
//   rst       : asynchronous active-high reset
//   gate_req  : level request to load gate_mask, held until gate_ack
//   gate_mask : requested mask {clk4f, clk2f, clk}, stable while gate_req=1
//   gate_ack  : one-cycle pulse in the cycle the new mask becomes active
//   clk4f_out : clk32f/8, gated by mask bit 2
//   clk2f_out : clk32f/16, gated by mask bit 1
//   clk_out   : clk32f/32, gated by mask bit 0
//   en4f      : strobe in the last clk32f cycle of each clk4f period
//   en2f      : strobe in the last clk32f cycle of each clk2f period
//   en1f      : strobe in the last clk32f cycle of each clk period
//   listo     : derived clocks valid
//   fase      : current divide-counter value
// ---------------------------------------------------------------------------
module control_relojes
  import ctrl_relojes_pkg::*;
#(
  parameter int          CNT_W       = 5,
  parameter int          HOLD_CYCLES = 8,
  parameter logic [2:0]  MASK_RST    = 3'b111
) (
  input  logic             clk32f,
  input  logic             rst,
  input  logic             gate_req,
  input  logic [2:0]       gate_mask,
  output logic             gate_ack,
  output logic             clk4f_out,
  output logic             clk2f_out,
  output logic             clk_out,
  output logic             en4f,
  output logic             en2f,
  output logic             en1f,
  output logic             listo,
  output logic [CNT_W-1:0] fase
);

  state_t           state;
  logic [7:0]       hold_cnt;
  logic [2:0]       mask_act;
  logic [2:0]       pend_mask;
  logic             pend;

  logic [CNT_W-1:0] cnt;
  logic             tc4;
  logic             tc2;
  logic             tc1;
  logic             run;
  logic             hold_last;
  logic             capture;
  logic             apply;

  assign run       = (state == RUN);
  assign hold_last = (hold_cnt == 8'(HOLD_CYCLES - 1));

  // A new request is taken only when nothing is pending and the previous
  // ack is not being shown; a requester still holding gate_req one cycle
  // after its ack is therefore seen as a fresh request.
  assign capture = gate_req && !pend && !gate_ack;

  // Pending masks are applied either on the HOLD->RUN edge or on the edge
  // leaving cnt==all-ones, so the new mask starts at cnt=0 where every
  // derived clock is low and no runt pulse can appear.
  assign apply = pend && ((state == HOLD) ? hold_last : tc1);

  contador_div #(
    .CNT_W (CNT_W)
  ) u_contador (
    .clk32f (clk32f),
    .rst    (rst),
    .en     (run),
    .cnt    (cnt),
    .tc4    (tc4),
    .tc2    (tc2),
    .tc1    (tc1)
  );

  always_ff @(posedge clk32f or posedge rst) begin
    if (rst) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      mask_act  <= MASK_RST;
      pend_mask <= MASK_RST;
      pend      <= 1'b0;
      gate_ack  <= 1'b0;
    end else begin
      gate_ack <= 1'b0;

      if (capture) begin
        pend      <= 1'b1;
        pend_mask <= gate_mask;
      end

      case (state)
        HOLD: begin
          hold_cnt <= hold_cnt + 8'd1;
          if (hold_last) begin
            state <= RUN;
          end
        end
        RUN: begin
          hold_cnt <= hold_cnt;
        end
      endcase

      if (apply) begin
        mask_act <= pend_mask;
        pend     <= 1'b0;
        gate_ack <= 1'b1;
      end
    end
  end

  // Outputs are pure decodes of registered state, so an asynchronous reset
  // forces all of them low in the same instant.
  assign clk4f_out = run & cnt[B4F-1]   & mask_act[M_4F];
  assign clk2f_out = run & cnt[B2F-1]   & mask_act[M_2F];
  assign clk_out   = run & cnt[CNT_W-1] & mask_act[M_1F];
  assign en4f      = run & tc4 & mask_act[M_4F];
  assign en2f      = run & tc2 & mask_act[M_2F];
  assign en1f      = run & tc1 & mask_act[M_1F];
  assign listo     = run;
  assign fase      = cnt;

  // The ack always lands in the first cycle of a new counter period.
  ack_at_wrap: assert property (
    @(posedge clk32f) disable iff (rst) gate_ack |-> (run && cnt == '0)
  );

  // Nothing but listo and the counter may move while in HOLD.
  quiet_in_hold: assert property (
    @(posedge clk32f) disable iff (rst)
      !run |-> !(clk4f_out || clk2f_out || clk_out || en4f || en2f || en1f)
  );

endmodule

// File: doc/control_relojes.md
Name: control_relojes

Overview:
- Sequencing and gating controller for the clk32f-derived clock tree.
- Owns the free-running divide counter; produces clk4f (/8), clk2f (/16) and clk (/32) plus one-cycle enable strobes.
- Holds all outputs quiet for a fixed time after reset, then raises listo.
- Accepts run-time gating-mask changes through a req/ack handshake and applies them only at a glitch-free boundary.
- Sits between the clk32f source and the serializer/deserializer blocks that consume the divided clocks.

Parameters:
- CNT_W, 5, divide-counter width (clk32f/2^CNT_W = clk).
- HOLD_CYCLES, 8, clk32f cycles spent in HOLD after rst deasserts (range 1..255).
- MASK_RST, 3'b111, gating mask loaded at reset (bit2=clk4f, bit1=clk2f, bit0=clk).

Ports:
- clk32f  in  1  sole clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- gate_req  in  1  level request to load gate_mask; held until gate_ack.
- gate_mask  in  3  requested mask, stable while gate_req=1.
- gate_ack  out  1  one-cycle pulse when the new mask becomes active.
- clk4f_out  out  1  clk32f/8, 50% duty, gated by mask[2].
- clk2f_out  out  1  clk32f/16, gated by mask[1].
- clk_out  out  1  clk32f/32, gated by mask[0].
- en4f  out  1  strobe at the last clk32f cycle of each clk4f period.
- en2f  out  1  strobe at the last cycle of each clk2f period.
- en1f  out  1  strobe at the last cycle of each clk period.
- listo  out  1  clocks valid.
- fase  out  CNT_W  current counter value.

Behaviour:
- Reset (async, rst=1):
  - state=HOLD, hold_cnt=0, cnt=0, mask_act=MASK_RST, pend=0.
  - All outputs 0.
- HOLD:
  - hold_cnt increments each cycle; cnt stays 0; divided clocks, strobes and listo are 0.
  - When hold_cnt==HOLD_CYCLES-1, next state is RUN.
- RUN:
  - cnt increments by 1 every cycle and wraps 31->0 (mod 2^CNT_W).
  - listo=1 from the first RUN cycle onward.
- RUN outputs, all combinational from registered state:
  - clk4f_out=cnt[2]&mask_act[2]
  - clk2f_out=cnt[3]&mask_act[1]
  - clk_out=cnt[4]&mask_act[0]
  - en4f=(cnt[2:0]==7)&mask_act[2]
  - en2f=(cnt[3:0]==15)&mask_act[1]
  - en1f=(cnt==31)&mask_act[0]
- Timing from the first RUN cycle (cnt=0): clk4f_out first high at cycle 4, clk2f_out at 8, clk_out at 16.
- Handshake:
  - When gate_req=1, pend=0 and gate_ack=0, capture gate_mask into pend_mask and set pend=1.
  - In RUN, the pending mask applies on the edge where cnt==31. All three clock bits are 0 at cnt=0, so no glitch or runt is possible.
  - On that edge: mask_act<=pend_mask, pend<=0, and gate_ack=1 for exactly the cycle where cnt=0.
  - If the request is captured in HOLD, it applies on the HOLD->RUN edge; ack appears in the first RUN cycle.
  - gate_req arriving during a pending or ack cycle is not re-captured. The requester must drop gate_req after ack; if it is still high on the cycle after ack, it is captured again (repeat request).
  - gate_mask changes while pend=1 are ignored.
- Strobes at the apply edge: the cnt==31 cycle uses the old mask for its strobes; the cnt==0 cycle uses the new mask.
- Mask 3'b000 is legal: all clocks and strobes stay 0, while cnt and listo keep running.
- Reset mid-operation: every output drops to 0 asynchronously in the same instant, and any pending request is discarded (no ack).

Decomposition:
- Shared package ctrl_relojes_pkg holds:
  - state encoding: HOLD=1'b0, RUN=1'b1;
  - mask bit indices: M_4F=2, M_2F=1, M_1F=0;
  - divide-ratio constants DIV4F=8, DIV2F=16, DIV1F=32.
- One sub-module, contador_div: an enabled CNT_W-bit wrap counter with terminal-count decode (tc4, tc2, tc1).
- The top level keeps the FSM, hold counter, handshake and gating.

Test Plan:
- Reset sequence: rst high for 3 cycles, then low.
  - listo=0 and all clocks 0 for 8 cycles.
  - listo=1 in cycle 9; clk4f_out rises in RUN cycle 4, clk2f_out in cycle 8, clk_out in cycle 16.
- Frequency/strobes over 64 RUN cycles:
  - clk4f has 8 periods of 8, clk2f has 4 periods of 16, clk has 2 periods of 32.
  - en4f fires 8 times (at fase=7,15,23,31), en2f 4 times, en1f 2 times, each exactly 1 cycle wide.
- Gating: at fase=10, assert gate_req with mask=3'b101.
  - No change until fase=31; gate_ack=1 at fase=0.
  - From then clk2f_out=0 and en2f=0, while clk4f and clk stay uninterrupted and never truncated.
- Request in HOLD: gate_req with mask=3'b001 during cycle 2 after reset.
  - gate_ack in the first RUN cycle; only clk_out toggles.
- Repeat and ignore: keep gate_req high for 2 cycles after ack with mask=3'b010.
  - A second ack comes at the next wrap (fase=0), 32 cycles later.
  - A gate_mask change to 3'b111 while pend=1 has no effect.
- Reset mid-run: assert rst at fase=20 with a request pending.
  - All outputs drop to 0 immediately and no gate_ack is issued.
  - After release, mask=3'b111 and the HOLD/RUN sequence repeats.
